quadc_sync_ctrl: RTL and testbench



---
 rtl/quadc_ctrl_pkg.sv | 27 ++
 rtl/quadc_sync_period_chk.sv | 47 ++++
 rtl/quadc_sync_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_quadc_sync_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quadc_ctrl_pkg.sv
// Shared definitions for the quad-ADC sync bring-up controller:
// the state encoding, its width, and counter-sizing helpers.
package quadc_ctrl_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
   localparam logic [STATE_W-1:0] ST_DCM_RST   = 3'd1;
   localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd2;
   localparam logic [STATE_W-1:0] ST_IF_RST    = 3'd3;
   localparam logic [STATE_W-1:0] ST_WAIT_SYNC = 3'd4;
   localparam logic [STATE_W-1:0] ST_RUN       = 3'd5;
   localparam logic [STATE_W-1:0] ST_FAIL      = 3'd6;

   // Largest of three cycle-count parameters.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Bits needed to hold values 0..max_val (at least one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/quadc_sync_period_chk.sv
// Sync period checker: rising-edge detection on a registered copy of sync,
// a cycles-since-edge counter, and a one-cycle error pulse when an edge
// arrives off-period or the expected edge is overdue by one cycle.
// i_active keeps the counter alive (WAIT_SYNC and RUN); i_check enables
// error reporting and free counting (RUN only).
module quadc_sync_period_chk #(
   parameter int PERIOD_W = 32
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_sync,
   input  logic [PERIOD_W-1:0] i_sync_period,
   input  logic                i_active,
   input  logic                i_check,
   output logic                o_sync_edge,
   output logic                o_period_err
);

   logic                r_sync_d;
   logic [PERIOD_W:0]   r_cnt;
   logic [PERIOD_W:0]   w_period_ext;
   logic                w_chk_en;
   logic                w_overrun;

   // One extra bit so sync_period+1 never wraps.
   assign w_period_ext = {1'b0, i_sync_period};
   assign o_sync_edge  = i_sync & ~r_sync_d;
   assign w_chk_en     = i_check && (i_sync_period != '0);
   assign w_overrun    = (r_cnt == (w_period_ext + (PERIOD_W+1)'(1)));
   // An edge is judged on its arrival count; otherwise only the overdue point errors.
   assign o_period_err = w_chk_en && (o_sync_edge ? (r_cnt != w_period_ext) : w_overrun);

   // Registered copy of sync for edge detection (a held-high sync is one edge).
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sync_d <= 1'b0;
      else          r_sync_d <= i_sync;
   end

   // Cycles since the last edge or reload; edges and overruns restart at 1.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                           r_cnt <= '0;
      else if (!i_active)                     r_cnt <= '0;
      else if (o_sync_edge || (w_chk_en && w_overrun)) r_cnt <= (PERIOD_W+1)'(1);
      else if (i_check)                       r_cnt <= r_cnt + (PERIOD_W+1)'(1);
   end

endmodule

// File: rtl/quadc_sync_ctrl.sv
// Quad-ADC interface bring-up controller: pulses the DCM reset, waits for
// lock, pulses the interface reset, waits for the first sync edge and then
// supervises lock (and optionally the sync period) while running.
// Optional feature macro: QUADC_SYNC_CHECK_EN enables sync-period checking.
module quadc_sync_ctrl
   import quadc_ctrl_pkg::*;
#(
   parameter int DCM_RST_CYCLES = 16,
   parameter int IF_RST_CYCLES  = 8,
   parameter int LOCK_TIMEOUT   = 65535,
   parameter int PERIOD_W       = 32,
   parameter int ERR_W          = 16
) (
   input  logic                user_clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                valid,
   input  logic                sync,
   input  logic [PERIOD_W-1:0] sync_period,
   output logic                dcm_reset,
   output logic                adc_reset,
   output logic                running,
   output logic                timeout,
   output logic [ERR_W-1:0]    err_count,
   output logic [STATE_W-1:0]  state
);

   // One shared phase counter sized for the longest timed phase.
   localparam int CNT_W = cnt_width(max3(DCM_RST_CYCLES, IF_RST_CYCLES, LOCK_TIMEOUT));
   localparam logic [CNT_W-1:0] DCM_LAST  = CNT_W'(DCM_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] IF_LAST   = CNT_W'(IF_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

   logic [STATE_W-1:0] r_state;
   logic [STATE_W-1:0] w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_timeout_set;
   logic               r_running;
   logic               r_timeout;
   logic [ERR_W-1:0]   r_err;
   logic               w_sync_edge;
   logic               w_period_err;
   logic               w_err_event;

`ifdef QUADC_SYNC_CHECK_EN
   logic w_sync_active;
   logic w_sync_check;

   assign w_sync_active = (r_state == ST_WAIT_SYNC) || (r_state == ST_RUN);
   assign w_sync_check  = (r_state == ST_RUN);

   quadc_sync_period_chk #(
      .PERIOD_W (PERIOD_W)
   ) u_period_chk (
      .i_clk         (user_clk),
      .i_rst_n       (reset_n),
      .i_sync        (sync),
      .i_sync_period (sync_period),
      .i_active      (w_sync_active),
      .i_check       (w_sync_check),
      .o_sync_edge   (w_sync_edge),
      .o_period_err  (w_period_err)
   );
`else
   logic r_sync_d;
   logic w_unused_period;

   // Registered copy of sync; only the first-edge detection needs it here.
   always_ff @(posedge user_clk or negedge reset_n) begin
      if (!reset_n) r_sync_d <= 1'b0;
      else          r_sync_d <= sync;
   end

   assign w_sync_edge     = sync & ~r_sync_d;
   assign w_period_err    = 1'b0;
   assign w_unused_period = ^sync_period;
`endif

   // Next-state and phase-counter logic; start restarts from any state.
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_timeout_set = 1'b0;
      if (start) begin
         w_state_nxt = ST_DCM_RST;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
            end
            ST_DCM_RST: begin
               if (r_cnt == DCM_LAST) begin
                  w_state_nxt = ST_WAIT_LOCK;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            ST_WAIT_LOCK: begin
               if (valid) begin
                  w_state_nxt = ST_IF_RST;
                  w_cnt_nxt   = '0;
               end else if (LOCK_TIMEOUT != 0) begin
                  // A zero timeout waits for lock indefinitely.
                  if (r_cnt == LOCK_LAST) begin
                     w_state_nxt   = ST_FAIL;
                     w_cnt_nxt     = '0;
                     w_timeout_set = 1'b1;
                  end else begin
                     w_cnt_nxt = r_cnt + 1'b1;
                  end
               end
            end
            ST_IF_RST: begin
               if (r_cnt == IF_LAST) begin
                  w_state_nxt = ST_WAIT_SYNC;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            ST_WAIT_SYNC: begin
               if (w_sync_edge) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
               // Lock loss triggers an automatic re-lock.
               if (!valid) begin
                  w_state_nxt = ST_DCM_RST;
                  w_cnt_nxt   = '0;
               end
            end
            ST_FAIL: begin
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   // State and phase counter registers.
   always_ff @(posedge user_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // running lags the state by one cycle on both entry to and exit from RUN.
   always_ff @(posedge user_clk or negedge reset_n) begin
      if (!reset_n) r_running <= 1'b0;
      else          r_running <= (r_state == ST_RUN);
   end

   // Sticky lock-timeout flag, cleared only by start.
   always_ff @(posedge user_clk or negedge reset_n) begin
      if (!reset_n)           r_timeout <= 1'b0;
      else if (start)         r_timeout <= 1'b0;
      else if (w_timeout_set) r_timeout <= 1'b1;
   end

   // Coincident lock loss and period error count as a single event.
   assign w_err_event = (r_state == ST_RUN) && (!valid || w_period_err);

   // Saturating error counter, cleared by start.
   always_ff @(posedge user_clk or negedge reset_n) begin
      if (!reset_n)                         r_err <= '0;
      else if (start)                       r_err <= '0;
      else if (w_err_event && (r_err != '1)) r_err <= r_err + 1'b1;
   end

   assign state     = r_state;
   assign dcm_reset = (r_state == ST_DCM_RST);
   assign adc_reset = (r_state == ST_IF_RST);
   assign running   = r_running;
   assign timeout   = r_timeout;
   assign err_count = r_err;

endmodule

// File: tb/tb_quadc_sync_ctrl.sv
// Bench for quadc_sync_ctrl: directed bring-up, timeout, period and
// saturation scenarios plus a randomized phase, all scored per cycle
// against a behavioural model. Honours QUADC_SYNC_CHECK_EN when defined.
module tb_quadc_sync_ctrl;

   localparam int DCM_N  = 16;
   localparam int IF_N   = 8;
   localparam int LOCK_N = 100;
   localparam int PER_W  = 32;
   localparam int ERR_W  = 2;
   localparam int ERR_MAX = (1 << ERR_W) - 1;
   localparam int VEC_W  = 7 + ERR_W;

   // State codes as defined for the block's state output.
   localparam int S_IDLE = 0, S_DCM = 1, S_WLOCK = 2, S_IFR = 3, S_WSYNC = 4, S_RUN = 5, S_FAIL = 6;

`ifdef QUADC_SYNC_CHECK_EN
   localparam int CHK = 1;
`else
   localparam int CHK = 0;
`endif

   logic             user_clk = 1'b0;
   logic             reset_n  = 1'b1;
   logic             start    = 1'b0;
   logic             valid    = 1'b0;
   logic             sync     = 1'b0;
   logic [PER_W-1:0] sync_period = '0;
   logic             dcm_reset, adc_reset, running, timeout;
   logic [ERR_W-1:0] err_count;
   logic [2:0]       state;

   // clock
   always #5 user_clk = ~user_clk;

   quadc_sync_ctrl #(
      .DCM_RST_CYCLES (DCM_N),
      .IF_RST_CYCLES  (IF_N),
      .LOCK_TIMEOUT   (LOCK_N),
      .PERIOD_W       (PER_W),
      .ERR_W          (ERR_W)
   ) dut (
      .user_clk    (user_clk),
      .reset_n     (reset_n),
      .start       (start),
      .valid       (valid),
      .sync        (sync),
      .sync_period (sync_period),
      .dcm_reset   (dcm_reset),
      .adc_reset   (adc_reset),
      .running     (running),
      .timeout     (timeout),
      .err_count   (err_count),
      .state       (state)
   );

   logic [VEC_W-1:0] exp_q[$];
   int total = 0;
   int bad = 0;
   int n_print = 0;
   int cyc = 0;
   int dcm_hi_total = 0, adc_hi_total = 0, wlock_total = 0;

   // behavioural model
   int m_state, m_left, m_waited, m_err, m_ref;
   bit m_timeout, m_running, m_prev_sync;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (n_print < 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
         n_print++;
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_left = 0; m_waited = 0; m_err = 0; m_ref = 0;
      m_timeout = 0; m_running = 0; m_prev_sync = 0;
   endtask

   function automatic logic [VEC_W-1:0] exp_vec();
      return {3'(m_state), m_state == S_DCM, m_state == S_IFR, m_running, m_timeout, ERR_W'(m_err)};
   endfunction

   // One clock of the reference behaviour, using the inputs sampled at this edge.
   task automatic model_clock();
      bit edge_seen, perr, was_run;
      cyc++;
      if (!reset_n) begin
         model_reset();
         return;
      end
      edge_seen   = sync && !m_prev_sync;
      m_prev_sync = sync;
      was_run     = (m_state == S_RUN);
      perr        = 0;
      if (start) begin
         m_state = S_DCM; m_left = DCM_N; m_timeout = 0; m_err = 0;
      end else begin
         case (m_state)
            S_DCM: begin
               m_left--;
               if (m_left == 0) begin m_state = S_WLOCK; m_waited = 0; end
            end
            S_WLOCK: begin
               if (valid) begin
                  m_state = S_IFR; m_left = IF_N;
               end else begin
                  m_waited++;
                  if (LOCK_N != 0 && m_waited == LOCK_N) begin m_state = S_FAIL; m_timeout = 1; end
               end
            end
            S_IFR: begin
               m_left--;
               if (m_left == 0) m_state = S_WSYNC;
            end
            S_WSYNC: if (edge_seen) begin m_state = S_RUN; m_ref = cyc; end
            S_RUN: begin
               if (CHK != 0) begin
                  // Elapsed cycles since the reference edge must equal the period.
                  if (edge_seen) begin
                     if (sync_period != 0) perr = ((cyc - m_ref) != int'(sync_period));
                     m_ref = cyc;
                  end else if (sync_period != 0 && (cyc - m_ref) == int'(sync_period) + 1) begin
                     perr = 1; m_ref = cyc;
                  end
               end
               if (!valid || perr) m_err = (m_err >= ERR_MAX) ? ERR_MAX : m_err + 1;
               if (!valid) begin m_state = S_DCM; m_left = DCM_N; end
            end
            default: begin end
         endcase
      end
      m_running = was_run;
   endtask

   // driver tasks
   task automatic step();
      @(posedge user_clk);
      model_clock();
      exp_q.push_back(exp_vec());
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1; step(); start = 1'b0;
   endtask

   task automatic wait_model(input int s, input int budget, input string name);
      int n;
      n = 0;
      while (m_state != s && n < budget) begin step(); n++; end
      if (m_state != s) begin
         total++; bad++;
         $display("FAIL %s: state %0d not reached within %0d cycles", name, s, budget);
      end
   endtask

   task automatic sync_train(input int n, input int gap);
      int w;
      for (int k = 0; k < n; k++) begin
         w = $urandom_range(1, 6);
         sync = 1'b1; repeat (w) step();
         sync = 1'b0; repeat (gap - w) step();
      end
   endtask

   task automatic relock_and_drop();
      valid = 1'b1;
      wait_model(S_WSYNC, 60, "relock");
      sync = 1'b0; step(); sync = 1'b1; step(); sync = 1'b0;
      repeat (3) step();
      valid = 1'b0; step(); valid = 1'b1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_state"}, 32'(state), 0);
      check({tag, "_dcm"}, 32'(dcm_reset), 0);
      check({tag, "_adc"}, 32'(adc_reset), 0);
      check({tag, "_running"}, 32'(running), 0);
      check({tag, "_timeout"}, 32'(timeout), 0);
      check({tag, "_err"}, 32'(err_count), 0);
   endtask

   // scoreboard monitor: one expected vector per clock, compared mid-cycle
   always @(negedge user_clk) begin : mon
      logic [VEC_W-1:0] e;
      if (dcm_reset === 1'b1) dcm_hi_total++;
      if (adc_reset === 1'b1) adc_hi_total++;
      if (state === 3'd2) wlock_total++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sb_state",   32'(state),     32'(e[VEC_W-1 -: 3]));
         check("sb_dcm",     32'(dcm_reset), 32'(e[ERR_W+3]));
         check("sb_adc",     32'(adc_reset), 32'(e[ERR_W+2]));
         check("sb_running", 32'(running),   32'(e[ERR_W+1]));
         check("sb_timeout", 32'(timeout),   32'(e[ERR_W]));
         check("sb_err",     32'(err_count), 32'(e[ERR_W-1:0]));
      end
   end

   initial begin : main
      int base_d, base_a, base_w, gap_left, hi_left, base;
      model_reset();
      // reset asserted between clock edges
      #1 reset_n = 1'b0;
      #1 check_all_zero("reset");
      repeat (3) step();
      reset_n = 1'b1;
      repeat (2) step();

      // bring-up: valid rises 5 cycles into WAIT_LOCK
      base_d = dcm_hi_total; base_a = adc_hi_total;
      sync_period = 32'd64;
      valid = 1'b0;
      pulse_start();
      wait_model(S_WLOCK, 40, "to_wlock");
      repeat (4) step();
      valid = 1'b1;
      wait_model(S_WSYNC, 40, "to_wsync");
      check("bringup_state", 32'(state), S_WSYNC);
      check("dcm_hi_cycles", 32'(dcm_hi_total - base_d), DCM_N);
      check("adc_hi_cycles", 32'(adc_hi_total - base_a), IF_N);

      // ten clean periods of 64, then one short period of 63
      sync = 1'b0; repeat (3) step();
      sync_train(10, 64);
      sync_train(1, 63);
      check("run_after_train", 32'(running), 1);
      check("err_after_train", 32'(err_count), 0);
      sync_train(1, 64);
      check("err_short_period", 32'(err_count), 32'(CHK));
      // missing edge: overdue error at count 65
      repeat (66) step();
      check("err_overrun", 32'(err_count), 32'(2 * CHK));

      // lock loss in RUN (coincides with a second overrun when checking is on)
      valid = 1'b0; step(); valid = 1'b1;
      check("drop_state", 32'(state), S_DCM);
      check("drop_dcm", 32'(dcm_reset), 1);
      check("drop_err", 32'(err_count), 32'(1 + 2 * CHK));
      check("drop_running_lag", 32'(running), 1);
      step();
      check("drop_running", 32'(running), 0);

      // five lock losses saturate a 2-bit counter
      sync_period = '0;
      pulse_start();
      check("start_clears_err", 32'(err_count), 0);
      repeat (5) relock_and_drop();
      check("err_saturated", 32'(err_count), ERR_MAX);

      // lock timeout
      base_w = wlock_total;
      valid = 1'b0;
      pulse_start();
      wait_model(S_FAIL, 200, "to_fail");
      check("fail_state", 32'(state), S_FAIL);
      check("fail_timeout", 32'(timeout), 1);
      check("wlock_cycles", 32'(wlock_total - base_w), LOCK_N);
      repeat (5) begin
         valid = 1'($urandom_range(0, 1)); sync = 1'($urandom_range(0, 1)); step();
      end
      check("fail_hold", 32'(state), S_FAIL);
      check("fail_dcm", 32'(dcm_reset), 0);
      check("fail_adc", 32'(adc_reset), 0);
      valid = 1'b1;
      pulse_start();
      check("restart_timeout", 32'(timeout), 0);
      check("restart_state", 32'(state), S_DCM);

      // randomized operation
      gap_left = 0; hi_left = 0;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            start = 1'b1;
            case ($urandom_range(0, 2))
               0: sync_period = 32'd0;
               1: sync_period = 32'd20;
               default: sync_period = 32'd33;
            endcase
         end else begin
            start = 1'b0;
         end
         valid = ($urandom_range(0, 149) != 0);
         if (gap_left == 0) begin
            base = (sync_period == 0) ? 30 : int'(sync_period);
            gap_left = base - 1 + int'($urandom_range(0, 7));
            hi_left = $urandom_range(1, 4);
         end
         gap_left--;
         sync = (hi_left > 0);
         if (hi_left > 0) hi_left--;
         step();
      end
      start = 1'b0;

      // asynchronous reset in the middle of DCM_RST
      valid = 1'b1;
      pulse_start();
      repeat (5) step();
      check("pre_reset_dcm", 32'(dcm_reset), 1);
      @(negedge user_clk);
      #2 reset_n = 1'b0;
      #1 check_all_zero("async_reset");
      model_reset();
      repeat (2) step();
      reset_n = 1'b1;
      repeat (3) step();

      // drain the scoreboard
      repeat (3) @(negedge user_clk);
      #1;
      if (exp_q.size() != 0) begin
         total++; bad++;
         $display("FAIL drain: %0d expected entries left", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
